// File: rtl/register_bank_scoreboard_if.sv
// Write-back, issue and operand-select bus of the register bank, plus the
// parallel register outputs and scoreboard status it returns.
interface register_bank_scoreboard_if #(
  parameter int WIDTH = 16
);
  logic             wr_en;
  logic [2:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             issue_en;
  logic [2:0]       issue_addr;
  logic [2:0]       rd_sel0;
  logic [2:0]       rd_sel1;
  logic             rd_use0;
  logic             rd_use1;
  logic [WIDTH-1:0] reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7;
  logic [7:0]       pending;
  logic             stall;

  modport master (
    output wr_en, wr_addr, wr_data, issue_en, issue_addr,
           rd_sel0, rd_sel1, rd_use0, rd_use1,
    input  reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7, pending, stall
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, issue_en, issue_addr,
           rd_sel0, rd_sel1, rd_use0, rd_use1,
    output reg0, reg1, reg2, reg3, reg4, reg5, reg6, reg7, pending, stall
  );
endinterface

// File: rtl/register_bank_scoreboard.sv
// 8-entry register bank with one write port and a pending-write scoreboard
// that stalls readers and issuers of registers still awaiting write-back.
module register_bank_scoreboard #(
  parameter int               WIDTH       = 16,
  parameter int               ZERO_R0     = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  register_bank_scoreboard_if.slave bus
);
  localparam bit R0_HARD = (ZERO_R0 != 0);

  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];
  logic [7:0]       pending_q;
  logic [7:0]       pending_d;
  logic             stall;
  logic             wr_ok;
  logic             issue_ok;

  // Hazard check deliberately ignores a same-cycle write-back.
  always_comb begin
    stall = (bus.rd_use0  & pending_q[bus.rd_sel0])
          | (bus.rd_use1  & pending_q[bus.rd_sel1])
          | (bus.issue_en & pending_q[bus.issue_addr]);
  end

  always_comb begin
    wr_ok    = bus.wr_en & ~(R0_HARD && bus.wr_addr == 3'd0);
    issue_ok = bus.issue_en & ~stall & ~(R0_HARD && bus.issue_addr == 3'd0);
    for (int i = 0; i < 8; i++) regs_d[i] = regs_q[i];
    pending_d = pending_q;
    if (wr_ok) begin
      regs_d[bus.wr_addr]    = bus.wr_data;
      pending_d[bus.wr_addr] = 1'b0;
    end
    // Applied after the write so an issue to the same register keeps the bit.
    if (issue_ok) pending_d[bus.issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= RESET_VALUE;
      if (R0_HARD) regs_q[0] <= '0;
      pending_q <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) regs_q[i] <= regs_d[i];
      pending_q <= pending_d;
    end
  end

  assign bus.reg0    = regs_q[0];
  assign bus.reg1    = regs_q[1];
  assign bus.reg2    = regs_q[2];
  assign bus.reg3    = regs_q[3];
  assign bus.reg4    = regs_q[4];
  assign bus.reg5    = regs_q[5];
  assign bus.reg6    = regs_q[6];
  assign bus.reg7    = regs_q[7];
  assign bus.pending = pending_q;
  assign bus.stall   = stall;
endmodule
